// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request handshake plus response pulse.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [3:0]        req_be;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_be, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_be, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core (port 0) and debug (port 1); one transaction in flight,
// response MEM_LAT cycles after grant; requesters are stalled via req_ready outside the accept window.
module dmem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1,
   parameter int FAIR    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     core,
   dmem_arbiter_if.slave     dbg,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);
   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

   state_t     state, state_d;
   logic [2:0] cnt, cnt_d;
   logic       last_grant, last_grant_d;
   logic       owner_d;
   logic       owner_we, owner_we_d;

   logic window, rsp_cycle, gnt, winner;

   assign rsp_cycle = (state == WAIT) && (cnt == 3'd0);
   assign window    = (state == IDLE) || rsp_cycle;
   assign gnt       = window && (core.req_valid || dbg.req_valid);

   // On conflict, round-robin flips away from the last winner; fixed mode always favours the core.
   always_comb begin
      if (core.req_valid && dbg.req_valid)
         winner = (FAIR != 0) ? ~last_grant : 1'b0;
      else
         winner = dbg.req_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         owner_we   <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         last_grant <= last_grant_d;
         owner      <= owner_d;
         owner_we   <= owner_we_d;
      end
   end

   always_comb begin
      state_d        = state;
      cnt_d          = cnt;
      last_grant_d   = last_grant;
      owner_d        = owner;
      owner_we_d     = owner_we;
      core.req_ready = 1'b0;
      dbg.req_ready  = 1'b0;
      mem_en         = 1'b0;
      mem_we         = 1'b0;
      mem_be         = 4'b0000;
      mem_addr       = '0;
      mem_wdata      = '0;

      if (state == WAIT) begin
         if (cnt != 3'd0)
            cnt_d = cnt - 3'd1;
         else
            state_d = IDLE;
      end

      // A grant in the response cycle overrides the return to IDLE.
      if (gnt) begin
         core.req_ready = ~winner;
         dbg.req_ready  = winner;
         mem_en         = 1'b1;
         mem_we         = winner ? dbg.req_we    : core.req_we;
         mem_be         = winner ? dbg.req_be    : core.req_be;
         mem_addr       = winner ? dbg.req_addr  : core.req_addr;
         mem_wdata      = winner ? dbg.req_wdata : core.req_wdata;
         state_d        = WAIT;
         cnt_d          = LAT_M1;
         last_grant_d   = winner;
         owner_d        = winner;
         owner_we_d     = winner ? dbg.req_we : core.req_we;
      end
   end

   assign core.rsp_valid = rsp_cycle && !owner;
   assign dbg.rsp_valid  = rsp_cycle && owner;
   assign core.rsp_rdata = (rsp_cycle && !owner && !owner_we) ? mem_rdata : '0;
   assign dbg.rsp_rdata  = (rsp_cycle && owner && !owner_we) ? mem_rdata : '0;
   assign busy           = (state == WAIT);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: A = round-robin/MEM_LAT=1, B = fixed priority/MEM_LAT=1, C = round-robin/MEM_LAT=3.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_core ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_dbg ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_core ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_dbg ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) c_core ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) c_dbg ();

   logic        a_mem_en, a_mem_we, a_busy, a_owner;
   logic [3:0]  a_mem_be;
   logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        b_mem_en, b_mem_we, b_busy, b_owner;
   logic [3:0]  b_mem_be;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic        c_mem_en, c_mem_we, c_busy, c_owner;
   logic [3:0]  c_mem_be;
   logic [31:0] c_mem_addr, c_mem_wdata, c_mem_rdata;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .FAIR(1)) u_a (
      .clk(clk), .rst_n(rst_n), .core(a_core.slave), .dbg(a_dbg.slave),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner));

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .FAIR(0)) u_b (
      .clk(clk), .rst_n(rst_n), .core(b_core.slave), .dbg(b_dbg.slave),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner));

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .FAIR(1)) u_c (
      .clk(clk), .rst_n(rst_n), .core(c_core.slave), .dbg(c_dbg.slave),
      .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_be(c_mem_be), .mem_addr(c_mem_addr),
      .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata), .busy(c_busy), .owner(c_owner));

   // One-cycle read memory for DUT A; B and C see constant read data.
   always @(posedge clk) begin
      if (a_mem_en && !a_mem_we) begin
         case (a_mem_addr)
            32'h10:  a_mem_rdata <= 32'hDEAD_BEEF;
            32'h20:  a_mem_rdata <= 32'h1111_2222;
            32'h24:  a_mem_rdata <= 32'h3333_4444;
            default: a_mem_rdata <= 32'h0;
         endcase
      end
   end

   task automatic clear_inputs;
      a_core.req_valid = 0; a_core.req_we = 0; a_core.req_be = 4'hF; a_core.req_addr = 0; a_core.req_wdata = 0;
      a_dbg.req_valid  = 0; a_dbg.req_we  = 0; a_dbg.req_be  = 4'hF; a_dbg.req_addr  = 0; a_dbg.req_wdata  = 0;
      b_core.req_valid = 0; b_core.req_we = 0; b_core.req_be = 4'hF; b_core.req_addr = 0; b_core.req_wdata = 0;
      b_dbg.req_valid  = 0; b_dbg.req_we  = 0; b_dbg.req_be  = 4'hF; b_dbg.req_addr  = 0; b_dbg.req_wdata  = 0;
      c_core.req_valid = 0; c_core.req_we = 0; c_core.req_be = 4'hF; c_core.req_addr = 0; c_core.req_wdata = 0;
      c_dbg.req_valid  = 0; c_dbg.req_we  = 0; c_dbg.req_be  = 4'hF; c_dbg.req_addr  = 0; c_dbg.req_wdata  = 0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic test_reset;
      rst_n = 0;
      @(negedge clk);
      checks++;
      if (a_busy !== 0 || a_owner !== 0) begin
         failures++; $display("FAIL reset_busy_owner: busy=%b owner=%b required 0 0", a_busy, a_owner);
      end
      checks++;
      if (a_core.rsp_valid !== 0 || a_dbg.rsp_valid !== 0 || a_core.rsp_rdata !== 0 || a_dbg.rsp_rdata !== 0) begin
         failures++; $display("FAIL reset_rsp: core %b/%h dbg %b/%h required all 0",
                              a_core.rsp_valid, a_core.rsp_rdata, a_dbg.rsp_valid, a_dbg.rsp_rdata);
      end
      checks++;
      if (c_busy !== 0 || a_core.req_ready !== 0 || a_mem_en !== 0) begin
         failures++; $display("FAIL reset_idle: c_busy=%b ready=%b mem_en=%b required 0", c_busy, a_core.req_ready, a_mem_en);
      end
      tick();
      #1 rst_n = 1;
   endtask

   task automatic test_single_read;
      tick();
      a_core.req_valid = 1; a_core.req_we = 0; a_core.req_addr = 32'h10;
      @(negedge clk);
      checks++;
      if (a_core.req_ready !== 1 || a_mem_en !== 1 || a_mem_addr !== 32'h10 || a_mem_we !== 0 || a_dbg.req_ready !== 0) begin
         failures++; $display("FAIL single_grant: ready=%b mem_en=%b addr=%h we=%b required 1 1 10 0",
                              a_core.req_ready, a_mem_en, a_mem_addr, a_mem_we);
      end
      tick();
      a_core.req_valid = 0;
      @(negedge clk);
      checks++;
      if (a_core.rsp_valid !== 1 || a_core.rsp_rdata !== 32'hDEAD_BEEF || a_dbg.rsp_valid !== 0 || a_busy !== 1) begin
         failures++; $display("FAIL single_rsp: valid=%b rdata=%h dbg_valid=%b busy=%b required 1 deadbeef 0 1",
                              a_core.rsp_valid, a_core.rsp_rdata, a_dbg.rsp_valid, a_busy);
      end
      tick();
      @(negedge clk);
      checks++;
      if (a_core.rsp_valid !== 0 || a_busy !== 0) begin
         failures++; $display("FAIL single_done: rsp_valid=%b busy=%b required 0 0", a_core.rsp_valid, a_busy);
      end
   endtask

   task automatic test_fair_alternation;
      int core_n = 0;
      int dbg_n = 0;
      do_reset();
      a_core.req_valid = 1; a_core.req_addr = 32'h20;
      a_dbg.req_valid  = 1; a_dbg.req_addr  = 32'h24;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (a_core.req_ready === 1) core_n++;
         if (a_dbg.req_ready === 1) dbg_n++;
         checks++;
         if (a_core.req_ready !== ((i % 2) == 0) || a_dbg.req_ready !== ((i % 2) == 1) ||
             a_mem_addr !== (((i % 2) == 0) ? 32'h20 : 32'h24)) begin
            failures++; $display("FAIL rr_grant[%0d]: core_rdy=%b dbg_rdy=%b addr=%h required winner port %0d",
                                 i, a_core.req_ready, a_dbg.req_ready, a_mem_addr, i % 2);
         end
         if (i > 0) begin
            checks++;
            if (a_core.rsp_valid !== ((i % 2) == 1) || a_dbg.rsp_valid !== ((i % 2) == 0) ||
                (a_core.rsp_valid === 1 && a_core.rsp_rdata !== 32'h1111_2222) ||
                (a_dbg.rsp_valid === 1 && a_dbg.rsp_rdata !== 32'h3333_4444)) begin
               failures++; $display("FAIL rr_rsp[%0d]: core %b/%h dbg %b/%h required response on port %0d",
                                    i, a_core.rsp_valid, a_core.rsp_rdata, a_dbg.rsp_valid, a_dbg.rsp_rdata, (i - 1) % 2);
            end
         end
         tick();
      end
      a_core.req_valid = 0; a_dbg.req_valid = 0;
      @(negedge clk);
      checks++;
      if (a_dbg.rsp_valid !== 1 || a_dbg.rsp_rdata !== 32'h3333_4444 || a_core.rsp_valid !== 0) begin
         failures++; $display("FAIL rr_last_rsp: dbg %b/%h core %b required 1/33334444 0",
                              a_dbg.rsp_valid, a_dbg.rsp_rdata, a_core.rsp_valid);
      end
      checks++;
      if (core_n !== 3 || dbg_n !== 3) begin
         failures++; $display("FAIL rr_counts: core=%0d dbg=%0d required 3 3", core_n, dbg_n);
      end
   endtask

   task automatic test_fixed_priority;
      tick();
      b_mem_rdata = 32'h0BAD_F00D;
      b_core.req_valid = 1; b_core.req_addr = 32'h30;
      b_dbg.req_valid  = 1; b_dbg.req_addr  = 32'h34;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (b_core.req_ready !== 1 || b_dbg.req_ready !== 0) begin
            failures++; $display("FAIL fixed_grant[%0d]: core_rdy=%b dbg_rdy=%b required 1 0", i, b_core.req_ready, b_dbg.req_ready);
         end
         tick();
      end
      b_core.req_valid = 0;
      @(negedge clk);
      checks++;
      if (b_dbg.req_ready !== 1 || b_mem_addr !== 32'h34 || b_core.rsp_valid !== 1 || b_core.rsp_rdata !== 32'h0BAD_F00D) begin
         failures++; $display("FAIL fixed_release: dbg_rdy=%b addr=%h core_rsp=%b/%h required 1 34 1/0badf00d",
                              b_dbg.req_ready, b_mem_addr, b_core.rsp_valid, b_core.rsp_rdata);
      end
      tick();
      b_dbg.req_valid = 0;
      @(negedge clk);
      checks++;
      if (b_dbg.rsp_valid !== 1 || b_core.rsp_valid !== 0) begin
         failures++; $display("FAIL fixed_dbg_rsp: dbg=%b core=%b required 1 0", b_dbg.rsp_valid, b_core.rsp_valid);
      end
   endtask

   task automatic test_lat3_write_then_core;
      tick();
      c_mem_rdata = 32'hCAFE_0003;
      c_dbg.req_valid = 1; c_dbg.req_we = 1; c_dbg.req_be = 4'b0011;
      c_dbg.req_addr = 32'h40; c_dbg.req_wdata = 32'h1234;
      @(negedge clk);
      checks++;
      if (c_dbg.req_ready !== 1 || c_mem_en !== 1 || c_mem_we !== 1 || c_mem_be !== 4'b0011 ||
          c_mem_addr !== 32'h40 || c_mem_wdata !== 32'h1234) begin
         failures++; $display("FAIL lat3_grant: rdy=%b en=%b we=%b be=%b addr=%h wdata=%h required 1 1 1 0011 40 1234",
                              c_dbg.req_ready, c_mem_en, c_mem_we, c_mem_be, c_mem_addr, c_mem_wdata);
      end
      tick();
      c_dbg.req_valid = 0; c_dbg.req_we = 0;
      c_core.req_valid = 1; c_core.req_we = 0; c_core.req_addr = 32'h44;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         checks++;
         if (c_core.req_ready !== 0 || c_mem_en !== 0 || c_mem_addr !== 0 || c_busy !== 1 || c_owner !== 1 ||
             c_dbg.rsp_valid !== 0 || c_core.rsp_valid !== 0) begin
            failures++; $display("FAIL lat3_stall[+%0d]: rdy=%b en=%b addr=%h busy=%b owner=%b rsp=%b%b required 0 0 0 1 1 00",
                                 i, c_core.req_ready, c_mem_en, c_mem_addr, c_busy, c_owner, c_dbg.rsp_valid, c_core.rsp_valid);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (c_dbg.rsp_valid !== 1 || c_dbg.rsp_rdata !== 0 || c_core.rsp_valid !== 0) begin
         failures++; $display("FAIL lat3_wr_ack: dbg=%b/%h core=%b required 1/0 0", c_dbg.rsp_valid, c_dbg.rsp_rdata, c_core.rsp_valid);
      end
      checks++;
      if (c_core.req_ready !== 1 || c_mem_en !== 1 || c_mem_addr !== 32'h44 || c_mem_we !== 0) begin
         failures++; $display("FAIL lat3_regrant: rdy=%b en=%b addr=%h we=%b required 1 1 44 0",
                              c_core.req_ready, c_mem_en, c_mem_addr, c_mem_we);
      end
      tick();
      c_core.req_valid = 0;
      for (int i = 4; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (c_busy !== 1 || c_owner !== 0 || c_core.rsp_valid !== 0 || c_dbg.rsp_valid !== 0) begin
            failures++; $display("FAIL lat3_core_wait[+%0d]: busy=%b owner=%b rsp=%b%b required 1 0 00",
                                 i, c_busy, c_owner, c_core.rsp_valid, c_dbg.rsp_valid);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (c_core.rsp_valid !== 1 || c_core.rsp_rdata !== 32'hCAFE_0003 || c_dbg.rsp_valid !== 0) begin
         failures++; $display("FAIL lat3_core_rsp: core=%b/%h dbg=%b required 1/cafe0003 0",
                              c_core.rsp_valid, c_core.rsp_rdata, c_dbg.rsp_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (c_busy !== 0 || c_core.rsp_valid !== 0) begin
         failures++; $display("FAIL lat3_idle: busy=%b rsp=%b required 0 0", c_busy, c_core.rsp_valid);
      end
   endtask

   task automatic test_reset_mid;
      tick();
      c_core.req_valid = 1; c_core.req_we = 0; c_core.req_addr = 32'h48;
      @(negedge clk);
      checks++;
      if (c_core.req_ready !== 1) begin
         failures++; $display("FAIL rstmid_grant: ready=%b required 1", c_core.req_ready);
      end
      tick();
      c_core.req_valid = 0;
      #2 rst_n = 0;
      #1;
      checks++;
      if (c_busy !== 0 || c_owner !== 0) begin
         failures++; $display("FAIL rstmid_busy: busy=%b owner=%b required 0 0", c_busy, c_owner);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (c_core.rsp_valid !== 0 || c_dbg.rsp_valid !== 0 || c_busy !== 0) begin
            failures++; $display("FAIL rstmid_no_rsp[%0d]: rsp=%b%b busy=%b required 00 0",
                                 i, c_core.rsp_valid, c_dbg.rsp_valid, c_busy);
         end
         tick();
      end
      c_core.req_valid = 1; c_core.req_addr = 32'h50;
      c_dbg.req_valid  = 1; c_dbg.req_addr  = 32'h54;
      @(negedge clk);
      checks++;
      if (c_core.req_ready !== 1 || c_dbg.req_ready !== 0 || c_mem_addr !== 32'h50) begin
         failures++; $display("FAIL rstmid_first_conflict: core=%b dbg=%b addr=%h required 1 0 50",
                              c_core.req_ready, c_dbg.req_ready, c_mem_addr);
      end
      tick();
      c_core.req_valid = 0; c_dbg.req_valid = 0;
   endtask

   initial begin
      clear_inputs();
      b_mem_rdata = 0;
      c_mem_rdata = 0;
      test_reset();
      test_single_read();
      test_fair_alternation();
      test_fixed_priority();
      test_lat3_write_then_core();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
